clk_div_tick_gen: RTL and testbench

//  - Downstream consumer of the ripple divider's clk_div[31:0] bus. Picks one tap, synchronises it into the clk

---
 rtl/clk_div_tick_gen.sv | 187 ++++++++++++++++++
 tb/tb_clk_div_tick_gen.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_tick_gen.sv
// clk_div_tick_gen: selects one tap of the divider bus, synchronises it into
// the clk domain and converts each rising edge into a one-cycle tick enable.
// Bursts of burst_len ticks, or a continuous stream when burst_len is 0.
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   clk_div[31:0]     divider bus (bit 31 never toggles)
//   tap_sel, burst_len  latched when start is accepted in IDLE
//   start, stop       one-cycle control pulses
//   tick              one-cycle enable per tap rising edge (RUN only)
//   busy, done        status: ARM/RUN, and one-cycle burst completion
//   tick_count        ticks emitted in the current or last burst
// Macro TAP_GLITCH_FILTER_EN adds a 3-sample majority filter after the
// synchroniser (one extra cycle of latency, two extra ARM flush cycles).
module clk_div_tick_gen #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int MIN_TAP     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      clk_div,
    input  logic [4:0]       tap_sel,
    input  logic [CNT_W-1:0] burst_len,
    input  logic             start,
    input  logic             stop,
    output logic             tick,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] tick_count
);

`ifdef TAP_GLITCH_FILTER_EN
    localparam int ARM_CYCLES = SYNC_STAGES + 3;
`else
    localparam int ARM_CYCLES = SYNC_STAGES + 1;
`endif
    localparam int ARM_W = $clog2(ARM_CYCLES);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_CYCLES - 1);
    localparam logic [4:0] MIN_TAP_L = 5'(MIN_TAP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_DONE
    } state_t;

    state_t state_q, state_d;
    logic [ARM_W-1:0] arm_q, arm_d;
    logic [4:0] tap_q, tap_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic tick_q, tick_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic edge_q, edge_d;

    logic [4:0] tap_clamped;
    logic sync_out;
    logic filt;
    logic rise;
    logic last_tick;

    // Bit 31 is constant, so a request for it maps to the top live tap.
    always_comb begin
        if (tap_sel < MIN_TAP_L) begin
            tap_clamped = MIN_TAP_L;
        end else if (tap_sel == 5'd31) begin
            tap_clamped = 5'd30;
        end else begin
            tap_clamped = tap_sel;
        end
    end

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], clk_div[tap_q]};
        sync_out = sync_q[SYNC_STAGES-1];
    end

`ifdef TAP_GLITCH_FILTER_EN
    logic [1:0] hist_q, hist_d;

    // Majority of the current and two previous synchronised samples:
    // a single-cycle high or low excursion never changes the output.
    always_comb begin
        hist_d = {hist_q[0], sync_out};
        filt   = (sync_out & hist_q[0])
               | (sync_out & hist_q[1])
               | (hist_q[0] & hist_q[1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end
`else
    always_comb begin
        filt = sync_out;
    end
`endif

    always_comb begin
        edge_d    = filt;
        rise      = filt & ~edge_q;
        last_tick = tick_q && (len_q != '0) && (cnt_q == len_q);
    end

    always_comb begin
        state_d = state_q;
        arm_d   = arm_q;
        tap_d   = tap_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    tap_d   = tap_clamped;
                    len_d   = burst_len;
                    cnt_d   = '0;
                    arm_d   = '0;
                    state_d = S_ARM;
                end
            end
            // Pipeline still holds samples of the old tap; hold ticks off.
            S_ARM: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (arm_q == ARM_LAST) begin
                    state_d = S_RUN;
                end else begin
                    arm_d = arm_q + ARM_W'(1);
                end
            end
            // Completion is checked before stop so a final tick always
            // reports done, even if stop arrives alongside it.
            S_RUN: begin
                if (last_tick) begin
                    state_d = S_DONE;
                end else if (stop) begin
                    state_d = S_IDLE;
                end else if (rise) begin
                    tick_d = 1'b1;
                    cnt_d  = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            arm_q   <= '0;
            tap_q   <= MIN_TAP_L;
            len_q   <= '0;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            sync_q  <= '0;
            edge_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            arm_q   <= arm_d;
            tap_q   <= tap_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            sync_q  <= sync_d;
            edge_q  <= edge_d;
        end
    end

    always_comb begin
        tick       = tick_q;
        busy       = (state_q == S_ARM) || (state_q == S_RUN);
        done       = (state_q == S_DONE);
        tick_count = cnt_q;
    end

endmodule

// File: tb/tb_clk_div_tick_gen.sv
// Bench for clk_div_tick_gen: table of bursts, hand-written corner cases
// and random traffic, all checked cycle by cycle against a reference model.
module tb_clk_div_tick_gen;

    localparam int SYNC = 2;
    localparam int CW = 16;
    localparam int MIN_TAP = 2;
`ifdef TAP_GLITCH_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif
    localparam int LAT = FILT ? SYNC + 2 : SYNC + 1;
    localparam int ARMN = FILT ? SYNC + 3 : SYNC + 1;

    localparam int M_IDLE = 0;
    localparam int M_ARM = 1;
    localparam int M_RUN = 2;
    localparam int M_DONE = 3;

    logic clk = 1'b0;
    logic rst;
    logic [31:0] clk_div;
    logic [4:0] tap_sel;
    logic [CW-1:0] burst_len;
    logic start;
    logic stop;
    logic tick;
    logic busy;
    logic done;
    logic [CW-1:0] tick_count;

    clk_div_tick_gen #(
        .SYNC_STAGES(SYNC),
        .CNT_W(CW),
        .MIN_TAP(MIN_TAP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clk_div(clk_div),
        .tap_sel(tap_sel),
        .burst_len(burst_len),
        .start(start),
        .stop(stop),
        .tick(tick),
        .busy(busy),
        .done(done),
        .tick_count(tick_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // clk_div source: 0 counter, 1 random, 2 random with bit30 toggling, 3 hold
    int div_mode = 0;
    logic [31:0] div_cnt = '0;
    logic [31:0] hold_val = '0;

    // reference model state
    int m_state;
    int m_arm_left;
    logic [4:0] m_tap;
    logic [CW-1:0] m_len;
    logic [CW-1:0] m_cnt;
    bit m_tick;
    bit [7:0] hist;

    // latency tracking of one tap bit
    int trk_tap = -1;
    bit prev_bit;
    int rise_cyc;

    typedef struct {
        logic [4:0] ts;
        int len;
        int eff;
        int mode;
        bit mid;
        int exp_ticks;
        int exp_count;
    } vec_t;

    vec_t vecs[7];

    function automatic logic [4:0] eff_tap(input logic [4:0] t);
        int v;
        v = int'(t);
        if (v < MIN_TAP) v = MIN_TAP;
        if (v > 30) v = 30;
        return 5'(v);
    endfunction

    function automatic bit maj(input bit a, input bit b, input bit c);
        return (int'(a) + int'(b) + int'(c)) >= 2;
    endfunction

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0d expected %0d",
                     name, cyc, got, exp);
        end
    endtask

    // Advances the model by one clock edge using the pre-edge inputs.
    task automatic model_edge();
        bit v;
        bit ev;
        if (rst) begin
            m_state = M_IDLE;
            m_arm_left = 0;
            m_tap = 5'(MIN_TAP);
            m_len = '0;
            m_cnt = '0;
            m_tick = 1'b0;
            hist = '0;
            return;
        end
        v = clk_div[m_tap];
        hist = {hist[6:0], v};
        // a tap rise LAT cycles before the coming cycle
        if (FILT) begin
            ev = maj(hist[SYNC], hist[SYNC+1], hist[SYNC+2])
              && !maj(hist[SYNC+1], hist[SYNC+2], hist[SYNC+3]);
        end else begin
            ev = hist[SYNC] && !hist[SYNC+1];
        end
        case (m_state)
            M_IDLE: begin
                m_tick = 1'b0;
                if (start && !stop) begin
                    m_tap = eff_tap(tap_sel);
                    m_len = burst_len;
                    m_cnt = '0;
                    m_arm_left = ARMN;
                    m_state = M_ARM;
                end
            end
            M_ARM: begin
                m_tick = 1'b0;
                m_arm_left--;
                if (stop) m_state = M_IDLE;
                else if (m_arm_left == 0) m_state = M_RUN;
            end
            M_RUN: begin
                if (m_tick && m_len != 0 && m_cnt == m_len) begin
                    m_tick = 1'b0;
                    m_state = M_DONE;
                end else if (stop) begin
                    m_tick = 1'b0;
                    m_state = M_IDLE;
                end else begin
                    m_tick = ev;
                    if (ev) m_cnt = m_cnt + 1'b1;
                end
            end
            default: begin
                m_tick = 1'b0;
                m_state = M_IDLE;
            end
        endcase
    endtask

    task automatic drive_div();
        logic [31:0] r;
        r = $urandom();
        div_cnt = div_cnt + 1;
        case (div_mode)
            0: clk_div = {1'b0, div_cnt[29:0], 1'b0};
            1: clk_div = {1'b0, r[30:0]};
            2: clk_div = {1'b0, div_cnt[1], r[29:0]};
            default: clk_div = hold_val;
        endcase
    endtask

    task automatic check_out();
        bit eb;
        bit ed;
        eb = (m_state == M_ARM) || (m_state == M_RUN);
        ed = (m_state == M_DONE);
        checks++;
        if (tick !== m_tick || busy !== eb || done !== ed
            || tick_count !== m_cnt) begin
            errors++;
            $display("FAIL model cycle %0d tick/busy/done/cnt got %b%b%b/%0d expected %b%b%b/%0d",
                     cyc, tick, busy, done, tick_count,
                     m_tick, eb, ed, m_cnt);
        end
    endtask

    task automatic cyc_step();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        drive_div();
        check_out();
        if (trk_tap >= 0) begin
            if (tick === 1'b1) chk("latency", cyc - rise_cyc, LAT);
            if (clk_div[trk_tap] && !prev_bit) rise_cyc = cyc;
            prev_bit = clk_div[trk_tap];
        end
    endtask

    task automatic run_burst(input int idx);
        int nt;
        bit sd;
        div_mode = vecs[idx].mode;
        tap_sel = vecs[idx].ts;
        burst_len = CW'(vecs[idx].len);
        start = 1'b1;
        cyc_step();
        start = 1'b0;
        trk_tap = vecs[idx].eff;
        prev_bit = clk_div[trk_tap];
        rise_cyc = -1000;
        nt = 0;
        sd = 1'b0;
        for (int i = 0; i < 3000 && !sd; i++) begin
            if (vecs[idx].mid && i == 40) begin
                tap_sel = 5'd9;
                burst_len = CW'(2);
                start = 1'b1;
            end
            cyc_step();
            start = 1'b0;
            if (tick === 1'b1) nt++;
            if (done === 1'b1) sd = 1'b1;
        end
        trk_tap = -1;
        chk($sformatf("burst%0d_done", idx), sd, 1);
        chk($sformatf("burst%0d_ticks", idx), nt, vecs[idx].exp_ticks);
        chk($sformatf("burst%0d_count", idx), tick_count,
            vecs[idx].exp_count);
        chk($sformatf("burst%0d_busy", idx), busy, 0);
        cyc_step();
        chk($sformatf("burst%0d_done_1cyc", idx), done, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int nt;
        bit sd;

        vecs[0] = '{ts: 5'd4,  len: 5, eff: 4,  mode: 0, mid: 1'b0,
                    exp_ticks: 5, exp_count: 5};
        vecs[1] = '{ts: 5'd0,  len: 3, eff: 2,  mode: 0, mid: 1'b0,
                    exp_ticks: 3, exp_count: 3};
        vecs[2] = '{ts: 5'd1,  len: 4, eff: 2,  mode: 0, mid: 1'b0,
                    exp_ticks: 4, exp_count: 4};
        vecs[3] = '{ts: 5'd4,  len: 6, eff: 4,  mode: 0, mid: 1'b1,
                    exp_ticks: 6, exp_count: 6};
        vecs[4] = '{ts: 5'd3,  len: 2, eff: 3,  mode: 0, mid: 1'b0,
                    exp_ticks: 2, exp_count: 2};
        vecs[5] = '{ts: 5'd5,  len: 1, eff: 5,  mode: 0, mid: 1'b0,
                    exp_ticks: 1, exp_count: 1};
        vecs[6] = '{ts: 5'd31, len: 4, eff: 30, mode: 2, mid: 1'b0,
                    exp_ticks: 4, exp_count: 4};

        rst = 1'b1;
        clk_div = '0;
        tap_sel = '0;
        burst_len = '0;
        start = 1'b0;
        stop = 1'b0;

        // reset held with the divider running
        for (int i = 0; i < 3; i++) cyc_step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) cyc_step();

        for (int i = 0; i < 7; i++) run_burst(i);

        // continuous stream on tap 2, then stop
        div_mode = 0;
        tap_sel = 5'd2;
        burst_len = '0;
        start = 1'b1;
        cyc_step();
        start = 1'b0;
        nt = 0;
        sd = 1'b0;
        for (int i = 0; i < 2000 && nt < 300; i++) begin
            cyc_step();
            if (tick === 1'b1) nt++;
            if (done === 1'b1) sd = 1'b1;
        end
        chk("cont_ticks", nt, 300);
        chk("cont_no_done", sd, 0);
        chk("cont_count", tick_count, 300);
        stop = 1'b1;
        cyc_step();
        stop = 1'b0;
        chk("cont_stop_busy", busy, 0);
        chk("cont_stop_done", done, 0);
        for (int i = 0; i < 4; i++) cyc_step();
        chk("cont_hold_count", tick_count, 300);

        // start and stop together in IDLE
        start = 1'b1;
        stop = 1'b1;
        cyc_step();
        start = 1'b0;
        stop = 1'b0;
        chk("start_stop_busy", busy, 0);
        cyc_step();
        chk("start_stop_idle", busy, 0);

        // stop arriving in the same cycle as the final tick
        tap_sel = 5'd3;
        burst_len = CW'(2);
        start = 1'b1;
        cyc_step();
        start = 1'b0;
        nt = 0;
        for (int i = 0; i < 500 && nt < 2; i++) begin
            cyc_step();
            if (tick === 1'b1) nt++;
        end
        chk("final_ticks", nt, 2);
        stop = 1'b1;
        cyc_step();
        stop = 1'b0;
        chk("stop_on_final_done", done, 1);
        cyc_step();

        // single-cycle glitches on tap 4
        div_mode = 3;
        hold_val = '0;
        tap_sel = 5'd4;
        burst_len = '0;
        start = 1'b1;
        cyc_step();
        start = 1'b0;
        for (int i = 0; i < ARMN + 6; i++) cyc_step();
        hold_val = 32'h10;
        cyc_step();
        hold_val = '0;
        nt = (tick === 1'b1) ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
            cyc_step();
            if (tick === 1'b1) nt++;
        end
        chk("high_glitch_ticks", nt, FILT ? 0 : 1);
        hold_val = 32'h10;
        nt = 0;
        for (int i = 0; i < 12; i++) begin
            cyc_step();
            if (tick === 1'b1) nt++;
        end
        chk("steady_high_ticks", nt, 1);
        hold_val = '0;
        cyc_step();
        hold_val = 32'h10;
        nt = (tick === 1'b1) ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
            cyc_step();
            if (tick === 1'b1) nt++;
        end
        chk("low_glitch_ticks", nt, FILT ? 0 : 1);
        stop = 1'b1;
        cyc_step();
        stop = 1'b0;

        // random traffic: taps, lengths, start/stop and divider bits
        div_mode = 1;
        for (int i = 0; i < 1500; i++) begin
            tap_sel = 5'($urandom_range(0, 31));
            burst_len = CW'($urandom_range(0, 6));
            start = ($urandom_range(0, 9) == 0);
            stop = ($urandom_range(0, 39) == 0);
            cyc_step();
        end
        start = 1'b0;
        stop = 1'b1;
        cyc_step();
        stop = 1'b0;

        // asynchronous reset in the middle of a burst
        div_mode = 0;
        tap_sel = 5'd2;
        burst_len = CW'(50);
        start = 1'b1;
        cyc_step();
        start = 1'b0;
        for (int i = 0; i < 20; i++) cyc_step();
        chk("pre_rst_busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_tick", tick, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_count", tick_count, 0);
        for (int i = 0; i < 2; i++) cyc_step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) cyc_step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
